tri_state_buff: RTL and testbench

//  - Parallel-load storage register whose output drives a shared bus through tri-state buffers.
//  - Captures X on a clock edge when LOAD is high.
//  - Drives the stored word onto Y only while ENABLE is high; otherwise Y floats (high-Z).
//  - Used as a bus-attached register; several instances may share one Y net with exclusive ENABLEs.

---
 rtl/tri_state_buff.sv | 35 +++
 tb/tb_tri_state_buff.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tri_state_buff.sv
// Bus-attached parallel-load register with tri-state output driver.
// Optional even-parity output P when TSB_PARITY_EN is defined.
module tri_state_buff #(
  parameter int reg_size = 8
) (
  input  logic                CLOCK,
  input  logic                CLEAR,
  input  logic [reg_size-1:0] X,
  input  logic                LOAD,
  input  logic                ENABLE,
  output logic [reg_size-1:0] Y
`ifdef TSB_PARITY_EN
  ,
  output logic                P
`endif
);

  logic [reg_size-1:0] q;

  // CLEAR wins over LOAD; q only moves on a rising edge
  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      q <= '0;
    end else if (LOAD) begin
      q <= X;
    end
  end

  assign Y = ENABLE ? q : {reg_size{1'bz}};

`ifdef TSB_PARITY_EN
  assign P = ENABLE ? ^q : 1'bz;
`endif

endmodule

// File: tb/tb_tri_state_buff.sv
// Directed-vector bench for tri_state_buff (reg_size = 8).
// Undriven bus lines are pulled up, so a floating output reads as all ones.
module tb_tri_state_buff;

  logic       clk;
  logic       clear;
  logic [7:0] x;
  logic       load;
  logic       en;
  wire  [7:0] y;

  int nvec;
  int nbad;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (y[i]);
  end

`ifdef TSB_PARITY_EN
  wire p;
  pullup (p);
`endif

  tri_state_buff #(.reg_size(8)) dut (
    .CLOCK  (clk),
    .CLEAR  (clear),
    .X      (x),
    .LOAD   (load),
    .ENABLE (en),
    .Y      (y)
`ifdef TSB_PARITY_EN
    ,
    .P      (p)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec  = 0;
    nbad  = 0;
    clear = 1'b1;
    load  = 1'b0;
    en    = 1'b0;
    x     = 8'd100;

    #7;
    chk("rst_float", y, 8'hff);
    #3;
    en = 1'b1;
    #1;
    chk("rst_en", y, 8'h00);
    en    = 1'b0;
    clear = 1'b0;
    #1;
    load = 1'b1;
    x    = 8'd100;
    #5;
    chk("load_float", y, 8'hff);
    #5;
    load = 1'b0;
    #8;
    x = 8'd55;
    #52;
    chk("hold_float", y, 8'hff);
    en = 1'b1;
    #1;
    chk("en_now", y, 8'd100);
    tick();
    chk("hold_en1", y, 8'd100);
    tick();
    chk("hold_en2", y, 8'd100);
    en = 1'b0;
    #1;
    chk("dis_now", y, 8'hff);

    en   = 1'b1;
    load = 1'b1;
    x    = 8'h3c;
    #1;
    chk("old_q", y, 8'd100);
    tick();
    chk("new_q", y, 8'h3c);
    x = 8'h5a;
    tick();
    chk("track", y, 8'h5a);
    x = 8'h81;
    tick();
    chk("track2", y, 8'h81);
    load = 1'b0;
    x    = 8'h00;
    tick();
    chk("hold_ld0", y, 8'h81);

    #2;
    clear = 1'b1;
    load  = 1'b1;
    x     = 8'hff;
    #1;
    chk("clr_sync", y, 8'h81);
    tick();
    chk("clr_ld", y, 8'h00);
    clear = 1'b0;
    load  = 1'b0;
    en    = 1'b0;
    #1;
    chk("clr_float", y, 8'hff);

`ifdef TSB_PARITY_EN
    en   = 1'b1;
    load = 1'b1;
    x    = 8'h07;
    tick();
    chk("par_y7", y, 8'h07);
    chk("par_p7", {7'd0, p}, 8'h01);
    x = 8'h03;
    tick();
    load = 1'b0;
    chk("par_y3", y, 8'h03);
    chk("par_p3", {7'd0, p}, 8'h00);
    en = 1'b0;
    #1;
    chk("par_float", {7'd0, p}, 8'h01);
    clear = 1'b1;
    en    = 1'b1;
    tick();
    clear = 1'b0;
    chk("par_clr", {7'd0, p}, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
